// File: rtl/dmem_waitstate_pkg.sv
// Shared types and helpers for the wait-state data memory responder:
// FSM state encoding, store-size codes and the lane/alignment helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Byte-lane enables for an access of the given size at byte offset off.
  // Returns 4'b0000 for misaligned halves/words and for SZ_NONE (loads).
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] en;
    case (size)
      SZ_BYTE: en = 4'b0001 << off;
      SZ_HALF: begin
        if (off[0]) begin
          en = 4'b0000;
        end else if (off[1]) begin
          en = 4'b1100;
        end else begin
          en = 4'b0011;
        end
      end
      SZ_WORD: en = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Replicate right-justified store data onto every lane it could land in.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      SZ_WORD: d = wd;
      default: d = wd;
    endcase
    return d;
  endfunction

  // A store is misaligned when it enables no lanes; a load needs word alignment.
  function automatic logic is_misaligned(input logic [1:0] we, input logic re,
                                         input logic [1:0] off);
    logic mis;
    if (we != SZ_NONE) begin
      mis = (lane_en(we, off) == 4'b0000);
    end else if (re) begin
      mis = (off != 2'b00);
    end else begin
      mis = 1'b0;
    end
    return mis;
  endfunction

endpackage

// File: rtl/dmem_waitstate_if.sv
// CPU <-> data memory bus: request (size, load, address, store data) and
// response (read word, stall, misaligned pulse).
interface dmem_waitstate_if;
  logic [1:0]  we;
  logic        re;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        misaligned;

  modport master (
    output we, re, a, wd,
    input  rd, stall, misaligned
  );

  modport slave (
    input  we, re, a, wd,
    output rd, stall, misaligned
  );
endinterface

// File: rtl/dmem_waitstate_array.sv
// Word-organised storage with per-byte write enables and a registered read
// port. The read register captures the post-write word, so a store returns
// the merged result and a load (no enables) returns the stored word.
module dmem_array
  #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
  ) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
  );

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] merged_d;
  logic [31:0] rdata_q;

  // Word as it will look after this commit: enabled lanes from wdata.
  always_comb begin
    merged_d = mem_q[idx_i];
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        merged_d[8*i +: 8] = wdata_i[8*i +: 8];
      end else begin
        merged_d[8*i +: 8] = mem_q[idx_i][8*i +: 8];
      end
    end
  end

  // Byte-enabled write; contents are not reset, but reset suppresses writes.
  always_ff @(posedge clk) begin
    if (!rst && en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Registered read port; holds its value when no commit happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0000_0000;
    end else if (en_i) begin
      rdata_q <= merged_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_waitstate.sv
// Multi-cycle data-memory responder: accepts one load/store at a time,
// inserts WAIT_CYCLES wait states holding the pipeline via stall, commits on
// the edge entering DONE and flags misaligned accesses (which are dropped).
module dmem_waitstate
  import dmem_pkg::*;
  #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
  ) (
    input  logic              clk,
    input  logic              rst,
    dmem_waitstate_if.slave   bus
  );

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W+1:0]  a_q;
  logic [31:0]       wd_q;
  logic [1:0]        we_q;
  logic              re_q;
  logic              mis_q;

  logic              access_s;
  logic              commit_s;
  logic [IDX_W+1:0]  src_a_s;
  logic [31:0]       src_wd_s;
  logic [1:0]        src_we_s;
  logic              src_re_s;
  logic              mis_s;
  logic [3:0]        be_s;
  logic [31:0]       rd_s;
  logic              unused_s;

  assign access_s = (bus.we != SZ_NONE) || bus.re;
  assign unused_s = ^bus.a[31:IDX_W+2];

  // Commit source: live request when committing straight from IDLE
  // (zero wait states), otherwise the copy latched at acceptance.
  always_comb begin
    if (state_q == IDLE) begin
      src_a_s  = bus.a[IDX_W+1:0];
      src_wd_s = bus.wd;
      src_we_s = bus.we;
      src_re_s = bus.re;
    end else begin
      src_a_s  = a_q;
      src_wd_s = wd_q;
      src_we_s = we_q;
      src_re_s = re_q;
    end
  end

  // A store wins over a simultaneous load: lane_en is driven by size only.
  assign mis_s = is_misaligned(src_we_s, src_re_s, src_a_s[1:0]);
  assign be_s  = lane_en(src_we_s, src_a_s[1:0]);

  // Next-state logic, counter update and commit strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_s) begin
          cnt_d = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d  = DONE;
            commit_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = DONE;
          commit_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch, captured once when an access is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      wd_q <= 32'h0000_0000;
      we_q <= SZ_NONE;
      re_q <= 1'b0;
    end else if (state_q == IDLE && access_s) begin
      a_q  <= bus.a[IDX_W+1:0];
      wd_q <= bus.wd;
      we_q <= bus.we;
      re_q <= bus.re;
    end
  end

  // Misaligned pulse, high only during the DONE cycle of a dropped access.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= commit_s && mis_s;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .en_i    (commit_s && !mis_s),
    .be_i    (be_s),
    .idx_i   (src_a_s[IDX_W+1:2]),
    .wdata_i (lane_data(src_we_s, src_wd_s)),
    .rdata_o (rd_s)
  );

  assign bus.rd         = rd_s;
  assign bus.misaligned = mis_q;
  assign bus.stall      = ((state_q == IDLE) && access_s) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_waitstate.sv
// Directed bench for dmem_waitstate: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance share one clock and reset. Expected read words and
// misaligned flags are queued when a request is driven and compared in DONE.
module tb_dmem_waitstate;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_waitstate_if bus2 ();
  dmem_waitstate_if bus0 ();

  dmem_waitstate #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  dmem_waitstate #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd_sb [$];
  logic        mis_sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [1:0] we, input logic re,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel) begin
      bus0.we = we; bus0.re = re; bus0.a = a; bus0.wd = wd;
    end else begin
      bus2.we = we; bus2.re = re; bus2.a = a; bus2.wd = wd;
    end
  endtask

  function automatic logic stall_of(input bit sel);
    return sel ? bus0.stall : bus2.stall;
  endfunction

  function automatic logic [31:0] rd_of(input bit sel);
    return sel ? bus0.rd : bus2.rd;
  endfunction

  function automatic logic mis_of(input bit sel);
    return sel ? bus0.misaligned : bus2.misaligned;
  endfunction

  // One complete access: count stalled cycles, check DONE, then idle cycle.
  task automatic access(input bit sel, input string tag, input logic [1:0] we,
                        input logic re, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis);
    int n;
    int lat;
    lat = sel ? 1 : 3;
    rd_sb.push_back(exp_rd);
    mis_sb.push_back(exp_mis);
    @(negedge clk);
    drive(sel, we, re, a, wd);
    #1;
    n = 0;
    while (stall_of(sel) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " stall_cycles"}, 32'(n), 32'(lat));
    chk({tag, " rd"}, rd_of(sel), rd_sb.pop_front());
    chk({tag, " misaligned"}, {31'd0, mis_of(sel)}, {31'd0, mis_sb.pop_front()});
    drive(sel, SZ_NONE, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk({tag, " mis_cleared"}, {31'd0, mis_of(sel)}, 32'd0);
    chk({tag, " idle_stall"}, {31'd0, stall_of(sel)}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, SZ_NONE, 1'b0, 32'h0, 32'h0);
    drive(1'b1, SZ_NONE, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset rd2", bus2.rd, 32'h0);
    chk("reset mis2", {31'd0, bus2.misaligned}, 32'd0);
    chk("reset stall2", {31'd0, bus2.stall}, 32'd0);
    chk("reset rd0", bus0.rd, 32'h0);

    // Word store then load
    access(1'b0, "st10", SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    access(1'b0, "ld10", SZ_NONE, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte and half lanes
    access(1'b0, "st20", SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    access(1'b0, "sb21", SZ_BYTE, 1'b0, 32'h21, 32'h000000AB, 32'h0000AB00, 1'b0);
    access(1'b0, "sh22", SZ_HALF, 1'b0, 32'h22, 32'h00001234, 32'h1234AB00, 1'b0);
    access(1'b0, "ld20", SZ_NONE, 1'b1, 32'h20, 32'h0, 32'h1234AB00, 1'b0);

    // Misaligned accesses keep memory and rd unchanged
    access(1'b0, "sw13", SZ_WORD, 1'b0, 32'h13, 32'hFFFFFFFF, 32'h1234AB00, 1'b1);
    access(1'b0, "ld10b", SZ_NONE, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access(1'b0, "sh11", SZ_HALF, 1'b0, 32'h11, 32'h0000FFFF, 32'hDEADBEEF, 1'b1);
    access(1'b0, "ld10c", SZ_NONE, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access(1'b0, "ld12", SZ_NONE, 1'b1, 32'h12, 32'h0, 32'hDEADBEEF, 1'b1);

    // Reset in the first WAIT cycle aborts the store
    access(1'b0, "st30", SZ_WORD, 1'b0, 32'h30, 32'h11111111, 32'h11111111, 1'b0);
    @(negedge clk);
    drive(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h55555555);
    @(posedge clk);
    #1;
    chk("abort wait_stall", {31'd0, bus2.stall}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, SZ_NONE, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort rd", bus2.rd, 32'h0);
    chk("abort stall", {31'd0, bus2.stall}, 32'd0);
    access(1'b0, "ld30", SZ_NONE, 1'b1, 32'h30, 32'h0, 32'h11111111, 1'b0);

    // Store wins over load; address wraps modulo depth
    access(1'b0, "prio", SZ_WORD, 1'b1, 32'h10 + 32'd256, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
    access(1'b0, "ld10w", SZ_NONE, 1'b1, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);

    // Zero wait states, request held through DONE
    access(1'b1, "z_st8", SZ_WORD, 1'b0, 32'h8, 32'h0BADCAFE, 32'h0BADCAFE, 1'b0);
    rd_sb.push_back(32'h0BADCAFE);
    rd_sb.push_back(32'h0BADCAFE);
    @(negedge clk);
    drive(1'b1, SZ_NONE, 1'b1, 32'h8, 32'h0);
    #1;
    chk("z c0 stall", {31'd0, bus0.stall}, 32'd1);
    @(posedge clk);
    #1;
    chk("z c1 stall", {31'd0, bus0.stall}, 32'd0);
    chk("z c1 rd", bus0.rd, rd_sb.pop_front());
    @(posedge clk);
    #1;
    chk("z c2 stall", {31'd0, bus0.stall}, 32'd1);
    @(posedge clk);
    #1;
    chk("z c3 stall", {31'd0, bus0.stall}, 32'd0);
    chk("z c3 rd", bus0.rd, rd_sb.pop_front());
    drive(1'b1, SZ_NONE, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("z c4 stall", {31'd0, bus0.stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_waitstate.md
# dmem_waitstate

Multi-cycle data-memory responder for the rv32ipipelined core's data port: the memory end of the CPU's MemWrite/ALUResultM/WriteDataM/ReadDataMTick interface. It accepts one load or store at a time, inserts a configurable number of wait states, and holds the pipeline with `stall` until the access completes. It performs byte, half and word stores with lane enables, flags misaligned accesses, and returns a registered, word-aligned read word.

## Interface
- `DEPTH_WORDS`, 64: storage depth in 32-bit words; power of two, at least 2.
- `WAIT_CYCLES`, 2: extra wait states per access, 0 to 15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `we` input 2: store size; 00 = none, 01 = byte, 10 = half, 11 = word.
- `re` input 1: load request.
- `a` input 32: byte address; the word index is `a[$clog2(DEPTH_WORDS)+1:2]`.
- `wd` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `rd` output 32: registered full aligned word; valid in DONE.
- `stall` output 1: pipeline hold request.
- `misaligned` output 1: one-cycle pulse in DONE when the access was suppressed.

## Operation
- An access is `we != 0 || re`. If `we != 0` and `re` are both asserted, the store wins and the load is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, access present:
  - Latch `a`, `wd`, `we` and `re`.
  - Load the counter with `WAIT_CYCLES`.
  - Go to WAIT, or go straight to DONE if `WAIT_CYCLES == 0`.
- IDLE, no access: stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter equals 1, go to DONE on that edge.
- DONE: go to IDLE unconditionally. The request is still asserted in DONE but must not retrigger an access.
- The commit happens on the edge that enters DONE, using the latched values:
  - Store byte: lane `a[1:0]` gets `wd[7:0]`.
  - Store half: lanes `{a[1],1}:{a[1],0}` get `wd[15:0]`.
  - Store word: all four lanes are written.
  - Load: `rd` gets the stored word at the latched index. For a store, `rd` gets the post-write word.
- Misaligned means a half access with `a[0]=1`, or a word access or load with `a[1:0] != 0`. On a misaligned access, no lane is written, `rd` keeps its old value, and `misaligned=1` in DONE.
- Addresses beyond the depth wrap modulo `DEPTH_WORDS`, since upper address bits are ignored.
- `stall = (state==IDLE && access) || state==WAIT`. `stall` is combinational and low in DONE.
- The CPU holds its request stable while `stall=1`. The block relies only on its latched copy.

## Timing
- Access first presented in cycle 0:
  - `stall=1` in cycles 0 through `WAIT_CYCLES`.
  - DONE occurs in cycle `WAIT_CYCLES+1`, with `stall=0` and `rd` valid.
  - The next access is accepted no earlier than cycle `WAIT_CYCLES+2`.
- Throughput is one access per `WAIT_CYCLES+2` cycles. Back-to-back accesses pay the full latency each time.
- Reset values: state IDLE, counter 0, `rd=0`, `misaligned=0`.
  - `stall` reflects the inputs in the reset release cycle: 1 if an access is present.
  - Memory contents are not reset.
- Reset in WAIT, or on the commit edge, aborts the access: no lanes are written and `rd` is 0 after reset.
- A non-access cycle (`we=0`, `re=0`) in IDLE produces no state change and `stall=0`.

## Structure
- Package `dmem_pkg` holds:
  - the `state_t` enum (IDLE, WAIT, DONE);
  - size constants SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD;
  - function `lane_en(size, a[1:0])`, which returns a 4-bit enable and is 0 when the access is misaligned.
- Sub-module `dmem_array` holds the synchronous-write storage with 4-bit byte enables and a registered read port. It contains no FSM.
- The top-level `dmem_waitstate` contains the FSM, counter, request latch, misalignment check and `stall`.

## Test plan
- **Word store, then load.** Use `WAIT_CYCLES=2`.
  - Stimulus: `we=11`, `a=0x10`, `wd=0xDEADBEEF` at cycle 0.
  - Response: `stall` is high for cycles 0–2 and low in cycle 3 (DONE).
  - A later `re` at `a=0x10` must return `rd=0xDEADBEEF` in its DONE cycle.
- **Byte and half lanes.**
  - Stimulus: word `0x00000000` at `0x20`; then byte `wd=0xAB` at `0x21`; then half `wd=0x1234` at `0x22`.
  - Response: a load of `0x20` returns `0x1234AB00`.
- **Misaligned access.**
  - Stimulus: word store of `0xFFFFFFFF` at `0x13`.
  - Response: `misaligned=1` for exactly one cycle in DONE, and a load of `0x10` still returns `0xDEADBEEF`.
  - The same behaviour is required for a half store at `0x11`.
- **Zero wait states.** Use `WAIT_CYCLES=0`.
  - Stimulus: a load.
  - Response: `stall=1` only in cycle 0, DONE in cycle 1.
  - With the request held through DONE, the block returns to IDLE and starts exactly one new access in cycle 2.
- **Reset mid-operation.**
  - Stimulus: assert `rst` in the first WAIT cycle of a word store of `0x55555555` to `0x30`.
  - Response: the state returns to IDLE, `rd=0`, and a later load of `0x30` returns the pre-store contents.
- **Priority and wrap.**
  - Stimulus: `we=11` and `re=1` together, with `a = 0x10 + 4*DEPTH_WORDS`.
  - Response: the store lands at word index 4, and `rd` is the post-write word.
